secuenciador_mem: RTL and testbench
===================================

# secuenciador_mem

Vector memory-stage sequencer for the vector processor. It consumes the memory-stage control signals produced by the control unit (`mem_wr`, `sel_mem`, `sum_mem`) together with the EXE-stage address and store data. It then performs the vector load or store one element per granted request on a single-port data memory. While an access is in progress it stalls the pipeline. On completion it pulses `done` and presents any gathered load vector.

## Interface
- `VLEN`, default 4: elements per vector.
- `DATA_W`, default 16: element width in bits.
- `ADDR_W`, default 8: word address width.

- `clk`  in  1  clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  a memory-stage instruction is valid this cycle. Sampled only in IDLE.
- `mem_wr`  in  1  1 means store, 0 means load.
- `sel_mem`  in  1  unit-stride vector access.
- `sum_mem`  in  1  strided vector access. Has priority over `sel_mem`.
- `base_addr`  in  ADDR_W  address of element 0, from EXE.
- `stride`  in  ADDR_W  element step, used when `sum_mem`=1.
- `wdata_vec`  in  VLEN*DATA_W  store data. Element i occupies bits [i*DATA_W +: DATA_W].
- `rdata_vec`  out  VLEN*DATA_W  gathered load data, same element packing as `wdata_vec`.
- `stall`  out  1  pipeline hold; 1 whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable for the request.
- `mem_addr`  out  ADDR_W  request address.
- `mem_wdata`  out  DATA_W  store element.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rdata`  in  DATA_W  read data. Valid exactly one cycle after a granted read.

## Operation
- States are IDLE, ACCESS, DRAIN and DONE. Reset puts the FSM in IDLE.
- **IDLE, on `start`=1:**
  - Register `mem_wr`, the access mode, `wdata_vec` and the step. Step is `stride` if `sum_mem`=1, else 1.
  - Set address = `base_addr` and idx = 0.
  - If `sel_mem`=0 and `sum_mem`=0: no memory traffic, go to DONE.
  - Otherwise go to ACCESS.
- **ACCESS:**
  - Drive `mem_req`=1, `mem_we`=registered `mem_wr`, `mem_addr`=address, `mem_wdata`=element idx of the registered store data.
  - On `mem_gnt`=1: idx increments and address advances by step. Address wraps modulo 2^ADDR_W.
  - Without grant, all request outputs hold their values.
  - If the granted idx is VLEN-1: a store goes to DONE, a load goes to DRAIN.
- **Load data capture (every state):** the cycle after any granted read, `mem_rdata` is written into element (granted idx) of `rdata_vec`.
- **DRAIN:** `mem_req`=0. Captures the last element, then goes to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. Upstream must hold the instruction while `stall`=1.
- Elements of `rdata_vec` that a load has not rewritten keep their old values. A store never modifies `rdata_vec`.
- `stride`=0 is legal: all VLEN accesses go to `base_addr`.
- **Reset, including mid-access:**
  - FSM returns to IDLE immediately.
  - `stall`, `done`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `rdata_vec` = 0.
  - The interrupted access is abandoned. No replay.

## Timing
- `stall` and `done` are combinational decodes of state. `mem_*` outputs are registered or decoded from registered state. No combinational path from `mem_gnt` to `mem_req`.
- Latency with `mem_gnt` held at 1 and `start` in cycle 0:
  - Store: grants in cycles 1..VLEN, `done` in cycle VLEN+1.
  - Load: grants in cycles 1..VLEN, DRAIN in VLEN+1, `done` in VLEN+2.
  - No-op: `done` in cycle 1.
- Each cycle of `mem_gnt`=0 during ACCESS adds exactly one cycle.
- `stall` is high from cycle 1 through the `done` cycle inclusive, and low in the cycle after `done`.
- A new `start` is accepted in the first cycle after `done`, so back-to-back instructions have one IDLE cycle between them.

## Test plan
- **Unit-stride store:** VLEN=4, `base_addr`=0x10, `wdata_vec`={4,3,2,1}, `mem_gnt`=1.
  - Writes 1,2,3,4 to addresses 0x10..0x13 in cycles 1-4.
  - `done` in cycle 5; `stall` high in cycles 1-5.
- **Strided load:** `base_addr`=0x20, `stride`=3, memory returns addr+0x100.
  - Reads 0x20,0x23,0x26,0x29.
  - `rdata_vec`={0x129,0x126,0x123,0x120} when `done` pulses, in cycle 6.
- **Grant backpressure:** unit-stride load with `mem_gnt` low in cycles 2 and 3.
  - `mem_addr` holds 0x11 across those cycles.
  - `done` in cycle 8; data is correct.
- **Wrap-around:** `base_addr`=0xFE, `stride`=1, store.
  - Addresses 0xFE, 0xFF, 0x00, 0x01.
- **No-op and ignored start:** `start` with `sel_mem`=`sum_mem`=0.
  - `done` in cycle 1, `mem_req` never asserted.
  - A `start` pulse during ACCESS of a later instruction changes nothing.
- **Mid-access reset:** assert `rst_n`=0 after the second grant of a load.
  - All outputs are 0 immediately and the FSM is in IDLE.
  - After release, a new store completes normally.

Source files
------------

// File: rtl/secuenciador_mem_if.sv
// Bundle between the vector memory-stage sequencer and its surroundings: control-unit
// instruction fields, the gathered load vector and the single-port data memory request channel.
interface secuenciador_mem_if #(
    parameter int VLEN   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic                     mem_wr;
    logic                     sel_mem;
    logic                     sum_mem;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W-1:0]        stride;
    logic [VLEN*DATA_W-1:0]   wdata_vec;
    logic [VLEN*DATA_W-1:0]   rdata_vec;
    logic                     stall;
    logic                     done;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_gnt;
    logic [DATA_W-1:0]        mem_rdata;

    // The sequencer side.
    modport master (
        input  start, mem_wr, sel_mem, sum_mem, base_addr, stride, wdata_vec,
        input  mem_gnt, mem_rdata,
        output rdata_vec, stall, done, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Pipeline and memory side.
    modport slave (
        output start, mem_wr, sel_mem, sum_mem, base_addr, stride, wdata_vec,
        output mem_gnt, mem_rdata,
        input  rdata_vec, stall, done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/secuenciador_mem.sv
// Vector memory-stage sequencer: issues one element access per granted request on a
// single-port memory, stalls the pipeline meanwhile and gathers load data into rdata_vec.
module secuenciador_mem #(
    parameter int VLEN   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    secuenciador_mem_if.master   bus
);
    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       r_step;
    logic [IDX_W-1:0]        r_idx;
    logic [VLEN*DATA_W-1:0]  r_wdata;
    logic                    r_rd_pend;
    logic [IDX_W-1:0]        r_rd_idx;

    logic                    w_gnt_acc;
    logic                    w_last;
    logic [DATA_W-1:0]       w_wdata_elem [VLEN];

    assign w_gnt_acc = (r_state == S_ACCESS) && bus.mem_gnt;
    assign w_last    = (r_idx == IDX_W'(VLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_step    <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            // Remember which element a granted read belongs to; data arrives next cycle.
            r_rd_pend <= w_gnt_acc && !r_we;
            r_rd_idx  <= r_idx;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_we    <= bus.mem_wr;
                        r_wdata <= bus.wdata_vec;
                        r_step  <= bus.sum_mem ? bus.stride : ADDR_W'(1);
                        r_addr  <= bus.base_addr;
                        r_idx   <= '0;
                        r_state <= (bus.sel_mem || bus.sum_mem) ? S_ACCESS : S_DONE;
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_gnt) begin
                        r_addr <= r_addr + r_step;
                        r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
                        if (w_last) begin
                            r_state <= r_we ? S_DONE : S_DRAIN;
                        end
                    end
                end
                S_DRAIN: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Each gathered element lives in its own register so untouched lanes keep old data.
    generate
        for (genvar gi = 0; gi < VLEN; gi++) begin : g_lane
            logic [DATA_W-1:0] r_elem;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_elem <= '0;
                end else if (r_rd_pend && (r_rd_idx == IDX_W'(gi))) begin
                    r_elem <= bus.mem_rdata;
                end
            end

            assign bus.rdata_vec[gi*DATA_W +: DATA_W] = r_elem;
            assign w_wdata_elem[gi] = r_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign bus.stall     = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.mem_req   = (r_state == S_ACCESS);
    assign bus.mem_we    = (r_state == S_ACCESS) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_wdata_elem[r_idx];
endmodule

// File: tb/tb_secuenciador_mem.sv
// Bench for secuenciador_mem: directed table of test-plan cases, random instructions against
// an element-level reference model, plus reset and back-to-back sequences.
module tb_secuenciador_mem;
    localparam int VLEN = 4;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int VW   = VLEN * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    secuenciador_mem_if #(.VLEN(VLEN), .DATA_W(DW), .ADDR_W(AW)) bus ();
    secuenciador_mem #(.VLEN(VLEN), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wd;
    } acc_t;

    typedef struct {
        logic          wr;
        logic          sel;
        logic          sum;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [VW-1:0] wd;
        logic [31:0]   gmask;
        int            spur;
        int            exp_done;
        logic [VW-1:0] exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem     [256];   // memory seen by the DUT
    logic [DW-1:0] ref_mem [256];   // memory as the model expects it
    logic [VW-1:0] model_rd;        // expected rdata_vec contents
    acc_t          obs_q [$];
    acc_t          exp_q [$];
    logic          log_stall [64];
    logic          log_req   [64];
    logic [AW-1:0] log_addr  [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic gnt_at(input logic [31:0] gmask, input int c);
        return (c < 32) ? gmask[c] : 1'b1;
    endfunction

    // Element-level model: grant k of the instruction lands on the k-th granted ACCESS cycle.
    task automatic model(input logic wr, input logic sel, input logic sum,
                         input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [VW-1:0] wd, input logic [31:0] gmask,
                         output int e_done, output logic [VW-1:0] e_rd);
        int            cyc;
        logic [AW-1:0] step;
        logic [AW-1:0] a;
        acc_t          e;
        exp_q.delete();
        step = sum ? stride : AW'(1);
        if (!(sel || sum)) begin
            e_done = 1;
        end else begin
            cyc = 1;
            for (int i = 0; i < VLEN; i++) begin
                while (!gnt_at(gmask, cyc)) cyc++;
                a    = AW'(int'(base) + i * int'(step));
                e.addr = a;
                e.we   = wr;
                e.wd   = wd[i*DW +: DW];
                exp_q.push_back(e);
                if (wr) ref_mem[a] = wd[i*DW +: DW];
                else    model_rd[i*DW +: DW] = ref_mem[a];
                cyc++;
            end
            e_done = (cyc - 1) + (wr ? 1 : 2);
        end
        e_rd = model_rd;
    endtask

    // Called #1 after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic run(input string tag, input logic wr, input logic sel, input logic sum,
                       input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input logic [VW-1:0] wd, input logic [31:0] gmask, input int spur,
                       input int exp_done, input logic [VW-1:0] exp_rd);
        int            done_at = -1;
        int            last = 0;
        logic [VW-1:0] rd_at_done = '0;
        logic [DW-1:0] pend = '0;
        bit            pend_v = 1'b0;
        bit            ok;
        acc_t          o;
        int            n;
        obs_q.delete();
        bus.start     = 1'b1;
        bus.mem_wr    = wr;
        bus.sel_mem   = sel;
        bus.sum_mem   = sum;
        bus.base_addr = base;
        bus.stride    = stride;
        bus.wdata_vec = wd;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) bus.start = (c == spur);
            if (c == spur) begin
                bus.sel_mem   = 1'b0;
                bus.sum_mem   = 1'b0;
                bus.mem_wr    = ~wr;
                bus.base_addr = ~base;
            end
            bus.mem_gnt   = gnt_at(gmask, c);
            bus.mem_rdata = pend_v ? pend : DW'($urandom);
            pend_v = 1'b0;
            log_stall[c] = bus.stall;
            log_req[c]   = bus.mem_req;
            log_addr[c]  = bus.mem_addr;
            if (bus.mem_req && bus.mem_gnt) begin
                o.addr = bus.mem_addr;
                o.we   = bus.mem_we;
                o.wd   = bus.mem_wdata;
                obs_q.push_back(o);
                if (bus.mem_we) begin
                    mem[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    pend   = mem[bus.mem_addr];
                    pend_v = 1'b1;
                end
            end
            if (bus.done && done_at < 0) begin
                done_at    = c;
                rd_at_done = bus.rdata_vec;
            end
            last = c;
            if (done_at >= 0 && c == done_at + 1) break;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        check({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
        ok = 1'b1;
        for (int c = 0; c <= last; c++)
            if (log_stall[c] !== ((c >= 1) && (c <= exp_done))) ok = 1'b0;
        check({tag, " stall_window"}, 64'(ok), 64'(1));
        check({tag, " n_access"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, " access"}, 64'({obs_q[i].addr, obs_q[i].we, obs_q[i].wd}),
                  64'({exp_q[i].addr, exp_q[i].we, exp_q[i].wd}));
        check({tag, " rdata_vec"}, 64'(rd_at_done), 64'(exp_rd));
        $display("txn %s wr=%0d sel=%0d sum=%0d base=%h stride=%h done@%0d accesses=%0d rdata=%h",
                 tag, wr, sel, sum, base, stride, done_at, obs_q.size(), rd_at_done);
    endtask

    vec_t tbl [8];

    initial begin
        int            e_done;
        logic [VW-1:0] e_rd;
        logic          wr, sel, sum;
        logic [AW-1:0] base, stride;
        logic [VW-1:0] wd;
        logic [31:0]   gmask;
        int            spur;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0004_0003_0002_0001, 32'hFFFF_FFFF, -1, 5, 64'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h20, 8'h03, 64'h0, 32'hFFFF_FFFF, -1, 6, 64'h0129_0126_0123_0120};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 32'hFFFF_FFF3, -1, 8, 64'h0004_0003_0002_0001};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'hFE, 8'h01, 64'h000D_000C_000B_000A, 32'hFFFF_FFFF, -1, 5, 64'h0004_0003_0002_0001};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h55, 8'h07, 64'h0, 32'hFFFF_FFFF, -1, 1, 64'h0004_0003_0002_0001};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 64'h0008_0007_0006_0005, 32'hFFFF_FFFF, 2, 5, 64'h0004_0003_0002_0001};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 64'h0, 32'hFFFF_FFFF, -1, 6, 64'h000B_000B_000B_000B};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h02, 64'h0, 32'hFFFF_FFFF, -1, 6, 64'h0126_0124_0122_0120};

        for (int a = 0; a < 256; a++) begin
            mem[a]     = DW'(a + 'h100);
            ref_mem[a] = DW'(a + 'h100);
        end
        model_rd = '0;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.sel_mem   = 1'b0;
        bus.sum_mem   = 1'b0;
        bus.base_addr = '0;
        bus.stride    = '0;
        bus.wdata_vec = '0;
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs",
              64'({bus.stall, bus.done, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'h0);
        check("reset rdata_vec", 64'(bus.rdata_vec), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases run back to back: each starts in the cycle after the previous done.
        for (int t = 0; t < 8; t++) begin
            model(tbl[t].wr, tbl[t].sel, tbl[t].sum, tbl[t].base, tbl[t].stride,
                  tbl[t].wd, tbl[t].gmask, e_done, e_rd);
            run($sformatf("tbl%0d", t), tbl[t].wr, tbl[t].sel, tbl[t].sum, tbl[t].base,
                tbl[t].stride, tbl[t].wd, tbl[t].gmask, tbl[t].spur, tbl[t].exp_done, tbl[t].exp_rd);
            if (t == 2)
                check("backpressure addr hold", 64'({log_req[2], log_addr[2], log_req[3], log_addr[3]}),
                      64'({1'b1, 8'h11, 1'b1, 8'h11}));
            if (t == 4) begin
                spur = 0;
                for (int c = 0; c < 3; c++) if (log_req[c]) spur = 1;
                check("noop mem_req", 64'(spur), 64'(0));
            end
        end

        // Reset after the second grant of a load: everything clears at once.
        bus.start     = 1'b1;
        bus.mem_wr    = 1'b0;
        bus.sel_mem   = 1'b1;
        bus.sum_mem   = 1'b0;
        bus.base_addr = 8'h30;
        bus.mem_gnt   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset stall", 64'(bus.stall), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midreset outputs",
              64'({bus.stall, bus.done, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'h0);
        check("midreset rdata_vec", 64'(bus.rdata_vec), 64'h0);
        model_rd = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("txn midreset load base=30 abandoned after two grants");
        model(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 64'h00F4_00F3_00F2_00F1, 32'hFFFF_FFFF, e_done, e_rd);
        run("post_reset", 1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 64'h00F4_00F3_00F2_00F1,
            32'hFFFF_FFFF, -1, 5, 64'h0);

        for (int r = 0; r < 40; r++) begin
            wr     = 1'($urandom);
            {sel, sum} = 2'($urandom_range(0, 3));
            base   = AW'($urandom);
            stride = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            wd     = {$urandom, $urandom};
            gmask  = $urandom | $urandom;
            spur   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : -1;
            model(wr, sel, sum, base, stride, wd, gmask, e_done, e_rd);
            run($sformatf("rnd%0d", r), wr, sel, sum, base, stride, wd, gmask, spur, e_done, e_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
